// File: rtl/mp_addsub_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mp_addsub_sequencer
// Description : Multi-precision add/subtract sequencer. Streams LIMBS 64-bit
//               limbs, least significant first, through one external
//               combinational 64-bit adder/subtractor. It chains the carry or
//               borrow from limb to limb and returns the full-width result
//               together with the final carry (for subtract, 1 = no borrow).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst             clock (rising edge), synchronous active-high reset
//   in_valid/in_ready    request handshake; in_op 0 = a+b, 1 = a-b
//   in_a, in_b           operands, limb k at [64k+63:64k]
//   out_valid/out_ready  result handshake
//   out_sum, out_carry   result and final adder carry-out
//   adder_a/b/s          drive the shared adder (s = invert-b and carry-in)
//   adder_sum/cout       results returned by the shared adder
// Optional build macro
//   MP_ADDSUB_FLAGS_EN   adds out_zero (result == 0) and out_ovf (signed
//                        two's-complement overflow of the full-width op)
// ============================================================================
module mp_addsub_sequencer #(
    parameter int LIMBS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_op,
    input  logic [64*LIMBS-1:0]  in_a,
    input  logic [64*LIMBS-1:0]  in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [64*LIMBS-1:0]  out_sum,
    output logic                 out_carry,
    output logic [63:0]          adder_a,
    output logic [63:0]          adder_b,
    output logic                 adder_s,
    input  logic [63:0]          adder_sum,
    input  logic                 adder_cout
`ifdef MP_ADDSUB_FLAGS_EN
    ,
    output logic                 out_zero,
    output logic                 out_ovf
`endif
);

    localparam int c_W     = 64 * LIMBS;
    localparam int c_IDX_W = $clog2(LIMBS);

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(LIMBS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [c_W-1:0]      r_a;
    logic [c_W-1:0]      r_b;
    logic [c_W-1:0]      r_sum;
    logic                r_op;
    logic                r_c;
    logic [c_IDX_W-1:0]  r_idx;

    logic                w_accept;
    logic                w_run;
    logic                w_last;
    logic [c_IDX_W+5:0]  w_base;
    logic [63:0]         w_a_k;
    logic [63:0]         w_b_k;

    // Bit offset of the current limb: idx * 64.
    assign w_base   = {r_idx, 6'd0};
    assign w_a_k    = r_a[w_base +: 64];
    assign w_b_k    = r_b[w_base +: 64];

    assign w_accept = (r_state == c_ST_IDLE) && in_valid;
    assign w_run    = (r_state == c_ST_RUN);
    assign w_last   = (r_idx == c_IDX_LAST);

    assign in_ready  = (r_state == c_ST_IDLE);
    assign out_valid = (r_state == c_ST_DONE);
    assign out_sum   = r_sum;
    assign out_carry = r_c;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (in_valid)  w_state_next = c_ST_RUN;
            c_ST_RUN:  if (w_last)    w_state_next = c_ST_DONE;
            c_ST_DONE: if (out_ready) w_state_next = c_ST_IDLE;
            default:                  w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand steering. The adder computes a + (b ^ {64{s}}) + s. For limbs
    // above 0 the carry register drives s, so b is pre-XORed with c as well
    // as op; the adder's own XOR with s cancels the c term, leaving
    // a_k + (b_k ^ op) + c.
    // ------------------------------------------------------------------------
    always_comb begin
        adder_a = 64'd0;
        adder_b = 64'd0;
        adder_s = 1'b0;
        if (w_run) begin
            adder_a = w_a_k;
            if (r_idx == '0) begin
                adder_s = r_op;
                adder_b = w_b_k;
            end else begin
                adder_s = r_c;
                adder_b = w_b_k ^ {64{r_op}} ^ {64{r_c}};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers. The previous result stays visible until the limbs
    // of a new request overwrite it one by one.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= 1'b0;
            r_idx <= '0;
            r_c   <= 1'b0;
            r_sum <= '0;
        end else begin
            if (w_accept) begin
                r_a   <= in_a;
                r_b   <= in_b;
                r_op  <= in_op;
                r_idx <= '0;
            end
            if (w_run) begin
                r_sum[w_base +: 64] <= adder_sum;
                r_c                 <= adder_cout;
                if (!w_last) begin
                    r_idx <= r_idx + c_IDX_ONE;
                end
            end
        end
    end

`ifdef MP_ADDSUB_FLAGS_EN
    logic r_zero;
    logic r_ovf;
    logic w_limb_zero;

    assign w_limb_zero = (adder_sum == 64'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_run) begin
            // Limb 0 restarts the AND chain.
            r_zero <= w_limb_zero & ((r_idx == '0) | r_zero);
            if (w_last) begin
                // Overflow: both effective operands share a sign that the
                // result does not.
                r_ovf <= (w_a_k[63] == (w_b_k[63] ^ r_op)) &&
                         (adder_sum[63] != w_a_k[63]);
            end
        end
    end

    assign out_zero = r_zero;
    assign out_ovf  = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mp_addsub_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mp_addsub_sequencer
// Description : Self-checking bench for mp_addsub_sequencer. Provides the
//               combinational 64-bit adder/subtractor and compares results
//               against a full-width arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mp_addsub_sequencer;

    localparam int LIMBS = 4;
    localparam int W     = 64 * LIMBS;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_carry;
    logic [63:0]   adder_a;
    logic [63:0]   adder_b;
    logic          adder_s;
    logic [63:0]   adder_sum;
    logic          adder_cout;
`ifdef MP_ADDSUB_FLAGS_EN
    logic          out_zero;
    logic          out_ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] obs_a [LIMBS];
    logic [63:0] obs_b [LIMBS];
    logic        obs_s [LIMBS];

    mp_addsub_sequencer #(.LIMBS(LIMBS)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_carry  (out_carry),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_s    (adder_s),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout)
`ifdef MP_ADDSUB_FLAGS_EN
        ,
        .out_zero   (out_zero),
        .out_ovf    (out_ovf)
`endif
    );

    // Shared adder: a + (b ^ {64{s}}) + s.
    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b ^ {64{adder_s}}} + 65'(adder_s);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Reference model: plain full-width unsigned arithmetic.
    // ------------------------------------------------------------------------
    function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                                      output logic [W-1:0] s, output logic c,
                                      output logic z, output logic v);
        logic [W:0] t;
        if (op) begin
            s = a - b;
            c = (a >= b);
            v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            t = {1'b0, a} + {1'b0, b};
            s = t[W-1:0];
            c = t[W];
            v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end
        z = (s == '0);
    endfunction

    // Carry into limb k of a + (b ^ op) + op, from the low 64k bits only.
    function automatic logic ref_cin(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input int k);
        logic [W-1:0] mask;
        logic [W-1:0] beff;
        logic [W:0]   t;
        if (k == 0) return op;
        mask = (W'(1) << (64 * k)) - W'(1);
        beff = op ? ~b : b;
        t = {1'b0, a & mask} + {1'b0, beff & mask} + (W + 1)'(op);
        return t[64 * k];
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        for (int k = 0; k < W / 32; k++) begin
            case ($urandom_range(0, 3))
                0:       r[32*k +: 32] = 32'h0;
                1:       r[32*k +: 32] = 32'hFFFF_FFFF;
                default: r[32*k +: 32] = $urandom;
            endcase
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Drive one request through to handoff; records adder port values per
    // RUN cycle into obs_*.
    // ------------------------------------------------------------------------
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                          input logic early_ready,
                          output logic [W-1:0] sum, output logic carry,
                          output logic zero, output logic ovf,
                          output int lat, output logic tmo);
        int n;
        sum = '0; carry = 1'b0; zero = 1'b0; ovf = 1'b0; lat = 0; tmo = 1'b0; n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            tmo = 1'b1;
            return;
        end
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = early_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        obs_a[0] = adder_a; obs_b[0] = adder_b; obs_s[0] = adder_s;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (lat < LIMBS) begin
                obs_a[lat] = adder_a; obs_b[lat] = adder_b; obs_s[lat] = adder_s;
            end
        end
        if (!out_valid) begin
            tmo = 1'b1;
            out_ready = 1'b0;
            return;
        end
        sum   = out_sum;
        carry = out_carry;
`ifdef MP_ADDSUB_FLAGS_EN
        zero  = out_zero;
        ovf   = out_ovf;
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_sum !== '0) $display("FAIL reset_out_sum: got %h want 0", out_sum); else n_pass++;
        n_checks++; if (out_carry !== 1'b0) $display("FAIL reset_out_carry: got %b want 0", out_carry); else n_pass++;
        n_checks++;
        if ({adder_a, adder_b, adder_s} !== '0)
            $display("FAIL reset_adder_ports: got a=%h b=%h s=%b want 0", adder_a, adder_b, adder_s);
        else n_pass++;
`ifdef MP_ADDSUB_FLAGS_EN
        n_checks++;
        if ({out_zero, out_ovf} !== 2'b00) $display("FAIL reset_flags: got %b%b want 00", out_zero, out_ovf); else n_pass++;
`endif
    endtask

    task automatic test_add_wrap();
        logic [W-1:0] s; logic c, z, v, tmo; int lat;
        run_op({W{1'b1}}, W'(1), 1'b0, 1'b0, s, c, z, v, lat, tmo);
        n_checks++; if (tmo !== 1'b0) $display("FAIL add_wrap_timeout: got %b want 0", tmo); else n_pass++;
        n_checks++; if (lat != LIMBS) $display("FAIL add_wrap_latency: got %0d want %0d", lat, LIMBS); else n_pass++;
        n_checks++; if (s !== '0) $display("FAIL add_wrap_sum: got %h want 0", s); else n_pass++;
        n_checks++; if (c !== 1'b1) $display("FAIL add_wrap_carry: got %b want 1", c); else n_pass++;
`ifdef MP_ADDSUB_FLAGS_EN
        n_checks++; if (z !== 1'b1) $display("FAIL add_wrap_zero: got %b want 1", z); else n_pass++;
`endif
    endtask

    task automatic test_sub_borrow();
        logic [W-1:0] s; logic c, z, v, tmo; int lat;
        run_op('0, W'(1), 1'b1, 1'b0, s, c, z, v, lat, tmo);
        n_checks++; if (tmo !== 1'b0) $display("FAIL sub_borrow_timeout: got %b want 0", tmo); else n_pass++;
        n_checks++; if (s !== {W{1'b1}}) $display("FAIL sub_borrow_sum: got %h want all ones", s); else n_pass++;
        n_checks++; if (c !== 1'b0) $display("FAIL sub_borrow_carry: got %b want 0", c); else n_pass++;
        n_checks++;
        if (obs_s[0] !== 1'b1 || obs_b[0] !== 64'd1)
            $display("FAIL sub_borrow_limb0: got s=%b b=%h want s=1 b=1", obs_s[0], obs_b[0]);
        else n_pass++;
        n_checks++;
        if (obs_s[1] !== 1'b0 || obs_b[1] !== 64'hFFFF_FFFF_FFFF_FFFF)
            $display("FAIL sub_borrow_limb1: got s=%b b=%h want s=0 b=ffffffffffffffff", obs_s[1], obs_b[1]);
        else n_pass++;
    endtask

    task automatic test_sub_equal();
        logic [W-1:0] a, s; logic c, z, v, tmo; int lat;
        a = {LIMBS{64'h0123_4567_89AB_CDEF}};
        run_op(a, a, 1'b1, 1'b0, s, c, z, v, lat, tmo);
        n_checks++; if (tmo !== 1'b0) $display("FAIL sub_equal_timeout: got %b want 0", tmo); else n_pass++;
        n_checks++; if (s !== '0) $display("FAIL sub_equal_sum: got %h want 0", s); else n_pass++;
        n_checks++; if (c !== 1'b1) $display("FAIL sub_equal_carry: got %b want 1", c); else n_pass++;
`ifdef MP_ADDSUB_FLAGS_EN
        n_checks++; if (z !== 1'b1) $display("FAIL sub_equal_zero: got %b want 1", z); else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, s, es; logic op, c, z, v, tmo, ec, ez, ev, cin; int lat;
        for (int i = 0; i < 24; i++) begin
            a  = rand_word();
            b  = (i % 5 == 0) ? a : rand_word();
            op = 1'($urandom_range(0, 1));
            ref_model(a, b, op, es, ec, ez, ev);
            run_op(a, b, op, 1'($urandom_range(0, 1)), s, c, z, v, lat, tmo);
            n_checks++; if (tmo !== 1'b0) $display("FAIL rand_timeout[%0d]: got %b want 0", i, tmo); else n_pass++;
            n_checks++; if (lat != LIMBS) $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, LIMBS); else n_pass++;
            n_checks++; if (s !== es) $display("FAIL rand_sum[%0d]: got %h want %h", i, s, es); else n_pass++;
            n_checks++; if (c !== ec) $display("FAIL rand_carry[%0d]: got %b want %b", i, c, ec); else n_pass++;
`ifdef MP_ADDSUB_FLAGS_EN
            n_checks++; if (z !== ez) $display("FAIL rand_zero[%0d]: got %b want %b", i, z, ez); else n_pass++;
            n_checks++; if (v !== ev) $display("FAIL rand_ovf[%0d]: got %b want %b", i, v, ev); else n_pass++;
`endif
            for (int k = 0; k < LIMBS; k++) begin
                cin = ref_cin(a, b, op, k);
                n_checks++;
                if (obs_a[k] !== a[64*k +: 64] || obs_s[k] !== cin ||
                    (obs_b[k] ^ {64{obs_s[k]}}) !== (b[64*k +: 64] ^ {64{op}}))
                    $display("FAIL rand_steer[%0d][%0d]: got a=%h b=%h s=%b want a=%h b^op=%h s=%b",
                             i, k, obs_a[k], obs_b[k], obs_s[k], a[64*k +: 64], b[64*k +: 64] ^ {64{op}}, cin);
                else n_pass++;
            end
        end
        // Unused in the default build.
        if (ez === 1'bx || ev === 1'bx || z === 1'bx || v === 1'bx) begin end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2, es1, es2; logic ec1, ec2, ez, ev; int n;
        a1 = rand_word(); b1 = rand_word();
        a2 = rand_word(); b2 = rand_word();
        ref_model(a1, b1, 1'b0, es1, ec1, ez, ev);
        ref_model(a2, b2, 1'b1, es2, ec2, ez, ev);
        in_valid = 1'b1; in_a = a1; in_b = b1; in_op = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        in_a = a2; in_b = b2; in_op = 1'b1;       // in_valid stays high: must be ignored
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        n_checks++; if (n != LIMBS) $display("FAIL bp_first_latency: got %0d want %0d", n, LIMBS); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++; if (out_sum !== es1) $display("FAIL bp_hold_sum[%0d]: got %h want %h", i, out_sum, es1); else n_pass++;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1)
                $display("FAIL bp_hold_hs[%0d]: got in_ready=%b out_valid=%b want 0 1", i, in_ready, out_valid);
            else n_pass++;
        end
        n_checks++; if (out_carry !== ec1) $display("FAIL bp_carry: got %b want %b", out_carry, ec1); else n_pass++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_after_handoff: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_second_accept: got in_ready=%b want 0", in_ready); else n_pass++;
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        n_checks++; if (n != LIMBS) $display("FAIL bp_second_latency: got %0d want %0d", n, LIMBS); else n_pass++;
        n_checks++; if (out_sum !== es2) $display("FAIL bp_second_sum: got %h want %h", out_sum, es2); else n_pass++;
        n_checks++; if (out_carry !== ec2) $display("FAIL bp_second_carry: got %b want %b", out_carry, ec2); else n_pass++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] a, b, s, es; logic c, z, v, tmo, ec, ez, ev, seen; int lat;
        a = rand_word(); b = rand_word();
        a[191:128] = 64'hDEAD_BEEF_0000_0001;
        in_valid = 1'b1; in_a = a; in_b = b; in_op = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (adder_a !== a[191:128]) $display("FAIL rst_run_idx2: got adder_a=%h want %h", adder_a, a[191:128]); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_run_in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_run_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_sum !== '0) $display("FAIL rst_run_out_sum: got %h want 0", out_sum); else n_pass++;
        n_checks++;
        if ({adder_a, adder_b, adder_s} !== '0)
            $display("FAIL rst_run_adder_ports: got a=%h b=%h s=%b want 0", adder_a, adder_b, adder_s);
        else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL rst_run_no_valid: got %b want 0", seen); else n_pass++;
        ref_model(a, b, 1'b1, es, ec, ez, ev);
        run_op(a, b, 1'b1, 1'b0, s, c, z, v, lat, tmo);
        n_checks++;
        if (tmo !== 1'b0 || s !== es || c !== ec)
            $display("FAIL rst_run_recover: got sum=%h carry=%b tmo=%b want %h %b 0", s, c, tmo, es, ec);
        else n_pass++;
    endtask

`ifdef MP_ADDSUB_FLAGS_EN
    task automatic test_flags_ovf();
        logic [W-1:0] a, s, es; logic c, z, v, tmo; int lat;
        a  = {1'b0, {(W-1){1'b1}}};
        es = {1'b1, {(W-1){1'b0}}};
        run_op(a, W'(1), 1'b0, 1'b0, s, c, z, v, lat, tmo);
        n_checks++; if (tmo !== 1'b0) $display("FAIL ovf_timeout: got %b want 0", tmo); else n_pass++;
        n_checks++; if (s !== es) $display("FAIL ovf_sum: got %h want %h", s, es); else n_pass++;
        n_checks++; if (v !== 1'b1) $display("FAIL ovf_flag: got %b want 1", v); else n_pass++;
        n_checks++; if (c !== 1'b0) $display("FAIL ovf_carry: got %b want 0", c); else n_pass++;
        n_checks++; if (z !== 1'b0) $display("FAIL ovf_zero: got %b want 0", z); else n_pass++;
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_add_wrap();
        test_sub_borrow();
        test_sub_equal();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
`ifdef MP_ADDSUB_FLAGS_EN
        test_flags_ovf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
